writeback_unit: RTL and testbench

//  MEM/WB pipeline register plus writeback: the write-side driver of the decode-stage register file.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/writeback_unit_load_align.sv | 49 ++++
 rtl/writeback_unit.sv | 167 ++++++++++++++++
 tb/tb_writeback_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the writeback stage: datapath width, result-source
//   encoding, load funct3 encodings and the writeback FSM state type.
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   // 2'b11 is reserved and is handled as RES_ALU by the result mux.
   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // IDLE: no response pending; WAIT: load in W, data not yet returned;
   // HOLD: data returned while W was held externally, kept in the buffer.
   typedef enum logic [1:0] {
      WB_IDLE = 2'b00,
      WB_WAIT = 2'b01,
      WB_HOLD = 2'b10
   } wb_state_t;

endpackage

// File: rtl/writeback_unit_load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Combinational load data aligner. Picks the addressed byte or halfword out
//   of a raw 32-bit memory word and sign- or zero-extends it, and flags
//   halfword/word accesses that are not naturally aligned.
// Ports
//   word_i        raw 32-bit word returned by data memory
//   offset_i      byte offset within the word (load address bits [1:0])
//   funct3_i      load size/sign encoding
//   data_o        aligned, extended load result
//   misaligned_o  LH/LHU with offset[0]=1, or LW with offset!=0
// -----------------------------------------------------------------------------
module load_align
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] word_i,
   input  logic [1:0]      offset_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o,
   output logic            misaligned_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every output of a combinational block gets a default on entry;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      byte_sel     = word_i[{offset_i, 3'b000} +: 8];
      half_sel     = offset_i[1] ? word_i[31:16] : word_i[15:0];
      data_o       = word_i;
      misaligned_o = 1'b0;
      case (funct3_i)
         F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU: data_o = {24'b0, byte_sel};
         F3_LH: begin
            data_o       = {{16{half_sel[15]}}, half_sel};
            misaligned_o = offset_i[0];
         end
         F3_LHU: begin
            data_o       = {16'b0, half_sel};
            misaligned_o = offset_i[0];
         end
         F3_LW:   misaligned_o = (offset_i != 2'b00);
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//   MEM/WB pipeline register plus writeback. Captures the MEM-stage
//   instruction, waits for a variable-latency load response (stalling the pipe
//   meanwhile), selects the result and issues one register-file write per
//   retired instruction. Also counts retired instructions.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   valid_m .. pc_plus4_m MEM-stage instruction fields
//   mem_rvalid/mem_rdata  data-memory read response (1-cycle pulse)
//   stall_in, flush_w     external hold / kill of the W stage
//   reg_write_w, rd_w,
//   result_w              register-file write port
//   stall_req             W cannot retire; upstream must hold
//   misaligned_w          load in W is misaligned (retires, no write)
//   retire, instret       retirement pulse and count
// -----------------------------------------------------------------------------
module writeback_unit #(
   parameter int XLEN      = riscv_pkg::XLEN,
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_m,
   input  logic                 reg_write_m,
   input  logic [1:0]           result_src_m,
   input  logic [2:0]           funct3_m,
   input  logic [4:0]           rd_m,
   input  logic [XLEN-1:0]      alu_result_m,
   input  logic [XLEN-1:0]      pc_plus4_m,
   input  logic                 mem_rvalid,
   input  logic [XLEN-1:0]      mem_rdata,
   input  logic                 stall_in,
   input  logic                 flush_w,
   output logic                 reg_write_w,
   output logic [4:0]           rd_w,
   output logic [XLEN-1:0]      result_w,
   output logic                 stall_req,
   output logic                 misaligned_w,
   output logic                 retire,
   output logic [INSTRET_W-1:0] instret
);

   import riscv_pkg::*;

   logic                 valid_w_q;
   logic                 reg_write_w_q;
   logic [1:0]           result_src_w_q;
   logic [2:0]           funct3_w_q;
   logic [4:0]           rd_w_q;
   logic [XLEN-1:0]      alu_w_q;
   logic [XLEN-1:0]      pc4_w_q;
   wb_state_t            state_q;
   logic [XLEN-1:0]      buffer_q;
   logic [INSTRET_W-1:0] instret_q;
   logic [INSTRET_W-1:0] instret_d;

   logic                 is_load;
   logic                 data_ready;
   logic [XLEN-1:0]      load_word;
   logic [XLEN-1:0]      load_data;
   logic                 load_mis;

   assign is_load    = valid_w_q & (result_src_w_q == RES_LOAD);
   // A response arriving this cycle is usable immediately; HOLD means the
   // data already sits in the buffer.
   assign data_ready = ~is_load | mem_rvalid | (state_q == WB_HOLD);
   assign stall_req  = valid_w_q & ~data_ready;
   assign retire     = valid_w_q & data_ready & ~stall_in & ~flush_w;

   assign load_word  = (state_q == WB_HOLD) ? buffer_q : mem_rdata;

   load_align u_load_align (
      .word_i       (load_word),
      .offset_i     (alu_w_q[1:0]),
      .funct3_i     (funct3_w_q),
      .data_o       (load_data),
      .misaligned_o (load_mis)
   );

   assign misaligned_w = is_load & load_mis;
   // A misaligned load still retires but must not corrupt rd.
   assign reg_write_w  = retire & reg_write_w_q & (rd_w_q != 5'd0) & ~misaligned_w;
   assign rd_w         = rd_w_q;
   assign instret      = instret_q;
   assign instret_d    = instret_q + INSTRET_W'(1);

   always_comb begin
      result_w = alu_w_q;
      case (result_src_w_q)
         RES_LOAD: result_w = load_data;
         RES_PC4:  result_w = pc4_w_q;
         default:  result_w = alu_w_q;
      endcase
   end

   // W pipeline register. A flush only clears valid; the payload is
   // don't-care once valid is low.
   // NOTE: clocked state is always written with non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the payload is reset as well, not just valid, so every
         // output (including result_w and rd_w) reads zero out of reset.
         valid_w_q      <= 1'b0;
         reg_write_w_q  <= 1'b0;
         result_src_w_q <= 2'b00;
         funct3_w_q     <= 3'b000;
         rd_w_q         <= 5'd0;
         alu_w_q        <= '0;
         pc4_w_q        <= '0;
      end else if (flush_w) begin
         valid_w_q <= 1'b0;
      end else if (!(stall_req | stall_in)) begin
         valid_w_q      <= valid_m;
         reg_write_w_q  <= reg_write_m;
         result_src_w_q <= result_src_m;
         funct3_w_q     <= funct3_m;
         rd_w_q         <= rd_m;
         alu_w_q        <= alu_result_m;
         pc4_w_q        <= pc_plus4_m;
      end
   end

   // Load-response FSM; at most one load outstanding. A response seen in
   // IDLE with no load in W is simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WB_IDLE;
         buffer_q <= '0;
      end else if (flush_w) begin
         state_q <= WB_IDLE;
      end else begin
         case (state_q)
            WB_IDLE: begin
               if (is_load && !mem_rvalid) begin
                  state_q <= WB_WAIT;
               end else if (is_load && mem_rvalid && stall_in) begin
                  state_q  <= WB_HOLD;
                  buffer_q <= mem_rdata;
               end
            end
            WB_WAIT: begin
               if (mem_rvalid && stall_in) begin
                  state_q  <= WB_HOLD;
                  buffer_q <= mem_rdata;
               end else if (mem_rvalid) begin
                  state_q <= WB_IDLE;
               end
            end
            WB_HOLD: begin
               if (!stall_in) state_q <= WB_IDLE;
            end
            default: state_q <= WB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_d;
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//   Directed bench for writeback_unit. A behavioural model tracks the
//   instruction sitting in W and whether its load data has been captured, and
//   a compare process checks every output on every negedge. Directed steps add
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_m, reg_write_m;
   logic [1:0]  result_src_m;
   logic [2:0]  funct3_m;
   logic [4:0]  rd_m;
   logic [31:0] alu_result_m, pc_plus4_m;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        stall_in, flush_w;
   logic        reg_write_w;
   logic [4:0]  rd_w;
   logic [31:0] result_w;
   logic        stall_req, misaligned_w, retire;
   logic [63:0] instret;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   writeback_unit #(.XLEN(32), .INSTRET_W(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_m      (valid_m),
      .reg_write_m  (reg_write_m),
      .result_src_m (result_src_m),
      .funct3_m     (funct3_m),
      .rd_m         (rd_m),
      .alu_result_m (alu_result_m),
      .pc_plus4_m   (pc_plus4_m),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .stall_in     (stall_in),
      .flush_w      (flush_w),
      .reg_write_w  (reg_write_w),
      .rd_w         (rd_w),
      .result_w     (result_w),
      .stall_req    (stall_req),
      .misaligned_w (misaligned_w),
      .retire       (retire),
      .instret      (instret)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic        rw;
      logic [1:0]  src;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] pc4;
   } instr_t;

   function automatic logic [31:0] load_value(input logic [31:0] w, input int off, input logic [2:0] f3);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic bit is_misaligned(input logic [2:0] f3, input int off);
      if (f3 == 3'b001 || f3 == 3'b101) return (off % 2) != 0;
      if (f3 == 3'b010) return off != 0;
      return 1'b0;
   endfunction

   bit          model_ok = 1'b0;
   bit          m_valid;
   bit          m_have;
   logic [31:0] m_word;
   logic [63:0] m_cnt;
   instr_t      m_ins;

   always @(negedge clk) begin : compare
      bit          is_ld, rdy, e_stall, e_ret, e_mis, e_we;
      int          off;
      logic [31:0] wd, e_res;
      is_ld = 1'b0; e_stall = 1'b0; e_ret = 1'b0;
      if (model_ok) begin
         is_ld   = m_valid && (m_ins.src == 2'b01);
         rdy     = !is_ld || mem_rvalid || m_have;
         e_stall = m_valid && !rdy;
         e_ret   = m_valid && rdy && !stall_in && !flush_w;
         off     = int'(m_ins.alu % 4);
         wd      = m_have ? m_word : mem_rdata;
         e_mis   = is_ld && is_misaligned(m_ins.f3, off);
         e_we    = e_ret && m_ins.rw && (m_ins.rd != 5'd0) && !e_mis;
         case (m_ins.src)
            2'b01:   e_res = load_value(wd, off, m_ins.f3);
            2'b10:   e_res = m_ins.pc4;
            default: e_res = m_ins.alu;
         endcase
         check("model.stall_req",    64'(stall_req),    64'(e_stall));
         check("model.retire",       64'(retire),       64'(e_ret));
         check("model.reg_write_w",  64'(reg_write_w),  64'(e_we));
         check("model.misaligned_w", 64'(misaligned_w), 64'(e_mis));
         check("model.instret",      instret,           m_cnt);
         if (e_we) begin
            check("model.rd_w",     64'(rd_w),     64'(m_ins.rd));
            check("model.result_w", 64'(result_w), 64'(e_res));
         end
      end
      // advance the model to what the coming posedge produces
      if (rst) begin
         m_valid  = 1'b0;
         m_have   = 1'b0;
         m_word   = '0;
         m_cnt    = '0;
         m_ins    = '{1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0};
         model_ok = 1'b1;
      end else if (flush_w) begin
         m_valid = 1'b0;
         m_have  = 1'b0;
      end else begin
         if (e_ret) m_cnt = m_cnt + 64'd1;
         if (is_ld && !m_have && mem_rvalid && stall_in) begin
            m_have = 1'b1;
            m_word = mem_rdata;
         end
         if (!(e_stall || stall_in)) begin
            m_valid = valid_m;
            m_ins   = '{reg_write_m, result_src_m, funct3_m, rd_m, alu_result_m, pc_plus4_m};
            m_have  = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction in MEM for a cycle; on return it sits in W.
   task automatic send(input logic rw, input logic [1:0] src, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4);
      valid_m      = 1'b1;
      reg_write_m  = rw;
      result_src_m = src;
      funct3_m     = f3;
      rd_m         = rd;
      alu_result_m = alu;
      pc_plus4_m   = pc4;
      tick();
      valid_m      = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] rdata;
      logic [31:0] exp;
   } load_vec_t;

   load_vec_t lvec[6];

   initial begin
      lvec[0] = '{3'b001, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001};  // LH upper, negative
      lvec[1] = '{3'b001, 2'd0, 32'h1234_F00D, 32'hFFFF_F00D};  // LH lower, negative
      lvec[2] = '{3'b100, 2'd1, 32'h0000_A500, 32'h0000_00A5};  // LBU byte 1
      lvec[3] = '{3'b000, 2'd0, 32'h0000_007F, 32'h0000_007F};  // LB positive
      lvec[4] = '{3'b010, 2'd0, 32'hCAFE_BABE, 32'hCAFE_BABE};  // LW
      lvec[5] = '{3'b101, 2'd0, 32'hFFFF_8000, 32'h0000_8000};  // LHU no sign

      rst = 1'b1; valid_m = 1'b0; reg_write_m = 1'b0; result_src_m = 2'b00;
      funct3_m = 3'b000; rd_m = 5'd0; alu_result_m = '0; pc_plus4_m = '0;
      mem_rvalid = 1'b0; mem_rdata = '0; stall_in = 1'b0; flush_w = 1'b0;
      repeat (2) tick();
      rst = 1'b0;

      // reset state
      @(negedge clk);
      check("rst.reg_write_w",  64'(reg_write_w),  64'd0);
      check("rst.rd_w",         64'(rd_w),         64'd0);
      check("rst.result_w",     64'(result_w),     64'd0);
      check("rst.stall_req",    64'(stall_req),    64'd0);
      check("rst.misaligned_w", 64'(misaligned_w), 64'd0);
      check("rst.retire",       64'(retire),       64'd0);
      check("rst.instret",      instret,           64'd0);
      tick();

      // ALU op, rd=5
      send(1'b1, 2'b00, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
      @(negedge clk);
      check("alu.reg_write_w", 64'(reg_write_w), 64'd1);
      check("alu.rd_w",        64'(rd_w),        64'd5);
      check("alu.result_w",    64'(result_w),    64'h1234);
      check("alu.retire",      64'(retire),      64'd1);
      tick();

      // LB off=3 with response in the same cycle
      send(1'b1, 2'b01, 3'b000, 5'd6, 32'h0000_1003, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FF00;
      @(negedge clk);
      check("lb.result_w",  64'(result_w),  64'hFFFF_FF80);
      check("lb.stall_req", 64'(stall_req), 64'd0);
      check("lb.reg_write", 64'(reg_write_w), 64'd1);
      tick();
      mem_rvalid = 1'b0;

      // LHU off=2, response three cycles late
      send(1'b1, 2'b01, 3'b101, 5'd7, 32'h0000_2002, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("lhu.stall_req", 64'(stall_req), 64'd1);
         check("lhu.no_write",  64'(reg_write_w), 64'd0);
         tick();
      end
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
      @(negedge clk);
      check("lhu.result_w",  64'(result_w),    64'h0000_80FF);
      check("lhu.reg_write", 64'(reg_write_w), 64'd1);
      check("lhu.stall_end", 64'(stall_req),   64'd0);
      tick();
      mem_rvalid = 1'b0;

      // response under stall_in -> held; a second response is ignored
      send(1'b1, 2'b01, 3'b010, 5'd8, 32'h0000_3000, 32'h0);
      stall_in = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("hold.retire0", 64'(retire), 64'd0);
      tick();
      mem_rdata = 32'h1111_1111;
      @(negedge clk);
      check("hold.retire1", 64'(retire), 64'd0);
      tick();
      stall_in = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      check("hold.result_w",  64'(result_w),    64'hDEAD_BEEF);
      check("hold.reg_write", 64'(reg_write_w), 64'd1);
      tick();
      @(negedge clk);
      check("hold.single_write", 64'(reg_write_w), 64'd0);
      tick();

      // misaligned LW retires without writing
      send(1'b1, 2'b01, 3'b010, 5'd9, 32'h0000_4001, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      check("mis.misaligned_w", 64'(misaligned_w), 64'd1);
      check("mis.reg_write_w",  64'(reg_write_w),  64'd0);
      check("mis.retire",       64'(retire),       64'd1);
      tick();
      mem_rvalid = 1'b0;

      // rd=0 never writes
      send(1'b1, 2'b00, 3'b000, 5'd0, 32'h0000_0055, 32'h0);
      @(negedge clk);
      check("x0.reg_write_w", 64'(reg_write_w), 64'd0);
      check("x0.retire",      64'(retire),      64'd1);
      tick();

      // alignment table, response with the instruction
      foreach (lvec[i]) begin
         send(1'b1, 2'b01, lvec[i].f3, 5'(11 + i), {30'h0000_1400, lvec[i].off}, 32'h0);
         mem_rvalid = 1'b1; mem_rdata = lvec[i].rdata;
         @(negedge clk);
         check("tbl.result_w", 64'(result_w), 64'(lvec[i].exp));
         tick();
         mem_rvalid = 1'b0;
      end

      // PC+4 select and reserved select treated as ALU
      send(1'b1, 2'b10, 3'b000, 5'd20, 32'h0000_0999, 32'h0000_0104);
      @(negedge clk);
      check("pc4.result_w", 64'(result_w), 64'h104);
      tick();
      send(1'b1, 2'b11, 3'b000, 5'd21, 32'h0000_0077, 32'h0000_0200);
      @(negedge clk);
      check("rsv.result_w", 64'(result_w), 64'h77);
      tick();

      // flush during WAIT; the late response is dropped
      send(1'b1, 2'b01, 3'b001, 5'd10, 32'h0000_6000, 32'h0);
      @(negedge clk);
      check("flush.stall_req", 64'(stall_req), 64'd1);
      tick();
      flush_w = 1'b1;
      @(negedge clk);
      check("flush.retire", 64'(retire), 64'd0);
      tick();
      flush_w = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
      @(negedge clk);
      check("flush.late_write", 64'(reg_write_w), 64'd0);
      check("flush.late_stall", 64'(stall_req),   64'd0);
      tick();
      mem_rvalid = 1'b0;
      @(negedge clk);
      check("flush.instret", instret, 64'd14);
      tick();

      // reset in the middle of a pending load
      send(1'b1, 2'b01, 3'b010, 5'd12, 32'h0000_7000, 32'h0);
      @(negedge clk);
      check("rstmid.stall_req", 64'(stall_req), 64'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0001;
      @(negedge clk);
      check("rstmid.instret",   instret,           64'd0);
      check("rstmid.reg_write", 64'(reg_write_w),  64'd0);
      check("rstmid.stall_req", 64'(stall_req),    64'd0);
      tick();
      mem_rvalid = 1'b0;
      send(1'b1, 2'b00, 3'b000, 5'd3, 32'h0000_0ABC, 32'h0);
      @(negedge clk);
      check("post.result_w",  64'(result_w),    64'hABC);
      check("post.reg_write", 64'(reg_write_w), 64'd1);
      tick();
      @(negedge clk);
      check("post.instret", instret, 64'd1);
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
